// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run-control sequencer for the 8-bit single-cycle CPU
//
// Holds the CPU in reset after power-up or soft reset, then gates CPU state
// updates through o_cpu_en. Supports start/resume, external halt, single-step,
// PC breakpoint, halt-opcode detection and an executed-cycle watchdog.
//
// Ports:
//   i_clk          clock
//   i_reset        asynchronous active-high reset
//   i_soft_rst     pulse: re-enter reset hold (synchronous, highest priority)
//   i_start        pulse: run from IDLE / resume from HALT
//   i_halt_req     level: stop before next instruction
//   i_step_req     pulse: execute exactly one instruction
//   i_bp_enable    breakpoint armed
//   i_bp_addr      breakpoint PC
//   i_pc           current CPU PC
//   i_instr        current CPU instruction (opcode in [23:20])
//   o_cpu_rst      registered reset to the CPU
//   o_cpu_en       CPU state-update enable
//   o_halted       high while halted
//   o_halt_cause   0 none, 1 ext, 2 bp, 3 halt-op, 4 watchdog, 5 step
//   o_cycle_count  instructions executed since last start from IDLE
module cpu_run_ctrl #(
  parameter int         PC_W        = 8,
  parameter int         CNT_W       = 16,
  parameter int         RST_CYCLES  = 4,
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int         WDOG_LIMIT  = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_soft_rst,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic             i_step_req,
  input  logic             i_bp_enable,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [23:0]      i_instr,
  output logic             o_cpu_rst,
  output logic             o_cpu_en,
  output logic             o_halted,
  output logic [2:0]       o_halt_cause,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_STEP     = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_EXT  = 3'd1;
  localparam logic [2:0] C_BP   = 3'd2;
  localparam logic [2:0] C_HOP  = 3'd3;
  localparam logic [2:0] C_WDOG = 3'd4;
  localparam logic [2:0] C_STEP = 3'd5;

  localparam int              HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  WDOG_CNT  = CNT_W'(WDOG_LIMIT);
  localparam logic              WDOG_ON   = (WDOG_LIMIT != 0);

  logic [2:0]        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_cpu_rst;
  logic              r_skip_bp;
  logic [2:0]        r_halt_cause;
  logic [CNT_W-1:0]  r_cycle_count;

  logic [2:0]        w_next_state;
  logic              w_is_halt_op;
  logic              w_bp_hit;
  logic              w_wdog_hit;
  logic [2:0]        w_run_stop_cause;
  logic [2:0]        w_step_stop_cause;
  logic              w_exec;
  logic              w_unused_instr;

  // Only the opcode field matters here.
  assign w_unused_instr = ^i_instr[19:0];

  assign w_is_halt_op = (i_instr[23:20] == HALT_OPCODE);
  // r_skip_bp lets a resume execute the instruction sitting on the breakpoint.
  assign w_bp_hit     = i_bp_enable && (i_pc == i_bp_addr) && !r_skip_bp;
  // Watchdog looks at executed cycles only, so halted time never counts.
  assign w_wdog_hit   = WDOG_ON && (r_cycle_count == WDOG_CNT);

  always_comb begin
    w_run_stop_cause = C_NONE;
    if (i_halt_req)        w_run_stop_cause = C_EXT;
    else if (w_bp_hit)     w_run_stop_cause = C_BP;
    else if (w_is_halt_op) w_run_stop_cause = C_HOP;
    else if (w_wdog_hit)   w_run_stop_cause = C_WDOG;

    // Breakpoint and watchdog do not apply to a single step.
    w_step_stop_cause = C_NONE;
    if (i_halt_req)        w_step_stop_cause = C_EXT;
    else if (w_is_halt_op) w_step_stop_cause = C_HOP;

    w_exec = 1'b0;
    case (r_state)
      S_RUN:   w_exec = (w_run_stop_cause == C_NONE);
      S_STEP:  w_exec = (w_step_stop_cause == C_NONE);
      default: w_exec = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST_HOLD: if (r_hold_cnt == HOLD_LAST) w_next_state = S_IDLE;
      S_IDLE, S_HALT: begin
        // A held halt request blocks both start and step.
        if (!i_halt_req) begin
          if (i_start)         w_next_state = S_RUN;
          else if (i_step_req) w_next_state = S_STEP;
        end
      end
      S_RUN:   if (!w_exec) w_next_state = S_HALT;
      S_STEP:  w_next_state = S_HALT;
      default: w_next_state = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_RST_HOLD;
      r_hold_cnt    <= '0;
      r_cpu_rst     <= 1'b1;
      r_skip_bp     <= 1'b0;
      r_halt_cause  <= C_NONE;
      r_cycle_count <= '0;
    end else if (i_soft_rst) begin
      r_state       <= S_RST_HOLD;
      r_hold_cnt    <= '0;
      r_cpu_rst     <= 1'b1;
      r_skip_bp     <= 1'b0;
      r_halt_cause  <= C_NONE;
      r_cycle_count <= '0;
    end else begin
      r_state   <= w_next_state;
      r_cpu_rst <= (w_next_state == S_RST_HOLD);

      if (r_state == S_RST_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;

      if (w_exec && (r_cycle_count != CNT_MAX)) r_cycle_count <= r_cycle_count + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_next_state == S_RUN) begin
            r_cycle_count <= '0;
            r_halt_cause  <= C_NONE;
            r_skip_bp     <= 1'b0;
          end else if (w_next_state == S_STEP) begin
            r_halt_cause  <= C_NONE;
          end
        end
        S_HALT: begin
          if (w_next_state == S_RUN) begin
            r_halt_cause <= C_NONE;
            r_skip_bp    <= 1'b1;
          end else if (w_next_state == S_STEP) begin
            r_halt_cause <= C_NONE;
          end
        end
        S_RUN: begin
          if (w_exec) r_skip_bp    <= 1'b0;
          else        r_halt_cause <= w_run_stop_cause;
        end
        S_STEP: begin
          r_halt_cause <= w_exec ? C_STEP : w_step_stop_cause;
        end
        default: ;
      endcase
    end
  end

  assign o_cpu_rst     = r_cpu_rst;
  assign o_cpu_en      = w_exec;
  assign o_halted      = (r_state == S_HALT);
  assign o_halt_cause  = r_halt_cause;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl with a toy CPU
module tb_cpu_run_ctrl;

  localparam int RSTC = 4;
  localparam int WDOG = 10;
  localparam int K_EXEC = 0;
  localparam int K_HALT = 1;
  localparam int K_RSTREL = 2;

  typedef struct {
    int kind;
    int pc;
    int cause;
    int count;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'h00;
  logic [7:0]  pc = 8'h00;
  logic [23:0] instr;
  logic        cpu_rst;
  logic        cpu_en;
  logic        halted;
  logic [2:0]  cause;
  logic [15:0] cnt;

  logic [3:0]  mem_op   [256];
  logic [7:0]  mem_next [256];
  logic [19:0] mem_lo   [256];

  int m_pc;
  int m_cnt;
  bit m_in_halt;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W(8), .CNT_W(16), .RST_CYCLES(RSTC), .HALT_OPCODE(4'hF), .WDOG_LIMIT(WDOG)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_soft_rst(soft_rst), .i_start(start),
    .i_halt_req(halt_req), .i_step_req(step_req), .i_bp_enable(bp_en),
    .i_bp_addr(bp_addr), .i_pc(pc), .i_instr(instr),
    .o_cpu_rst(cpu_rst), .o_cpu_en(cpu_en), .o_halted(halted),
    .o_halt_cause(cause), .o_cycle_count(cnt)
  );

  // Toy CPU: program memory plus a next-PC table.
  assign instr = {mem_op[pc], mem_lo[pc]};
  always @(posedge clk) begin
    if (cpu_rst)     pc <= 8'h00;
    else if (cpu_en) pc <= mem_next[pc];
  end

  task automatic push(input int k, input int p, input int c, input int n);
    ev_t e;
    e.kind = k; e.pc = p; e.cause = c; e.count = n;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_in_halt = 0;
    push(K_RSTREL, 0, 0, RSTC);
  endtask

  // Walks the program instruction by instruction from the spec's stop rules.
  task automatic model_run(input int hreq_at, input int cut_at, input bit cut_async,
                           output int last);
    bit resume;
    int c;
    resume = m_in_halt;
    if (!m_in_halt) m_cnt = 0;
    last = -1;
    for (int k = 0; k < 200; k++) begin
      if (k == cut_at && cut_async) begin last = k; break; end
      c = 0;
      if (k == hreq_at) c = 1;
      else if (bp_en && m_pc == int'(bp_addr) && !(resume && k == 0)) c = 2;
      else if (mem_op[m_pc] == 4'hF) c = 3;
      else if (m_cnt == WDOG) c = 4;
      if (c != 0) begin
        if (k != cut_at) begin
          push(K_HALT, m_pc, c, m_cnt);
          m_in_halt = 1;
        end
        last = k;
        break;
      end
      push(K_EXEC, m_pc, 0, m_cnt);
      if (m_cnt < 65535) m_cnt++;
      m_pc = int'(mem_next[m_pc]);
      if (k == cut_at) begin last = k; break; end
    end
    if (cut_at >= 0) model_reset();
  endtask

  task automatic do_run(input int hreq_at, input int cut_at, input bit cut_async);
    int last;
    int end_k;
    model_run(hreq_at, cut_at, cut_async, last);
    end_k = (cut_at > last) ? cut_at : last;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k <= end_k; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == hreq_at) halt_req = 1'b1;
      if (k == cut_at) begin
        if (cut_async) rst = 1'b1;
        else           soft_rst = 1'b1;
      end
    end
    @(posedge clk); #1 halt_req = 1'b0; soft_rst = 1'b0;
    if (rst) begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    end
    repeat (RSTC + 3) @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    if (mem_op[m_pc] == 4'hF) begin
      push(K_HALT, m_pc, 3, m_cnt);
    end else begin
      push(K_EXEC, m_pc, 0, m_cnt);
      if (m_cnt < 65535) m_cnt++;
      m_pc = int'(mem_next[m_pc]);
      push(K_HALT, m_pc, 5, m_cnt);
    end
    m_in_halt = 1;
    @(posedge clk); #1 step_req = 1'b1;
    @(posedge clk); #1 step_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_soft();
    model_reset();
    @(posedge clk); #1 soft_rst = 1'b1;
    @(posedge clk); #1 soft_rst = 1'b0;
    repeat (RSTC + 3) @(posedge clk);
    #1;
  endtask

  // Held halt request must swallow start and step: no events expected.
  task automatic do_blocked();
    halt_req = 1'b1;
    @(posedge clk); #1 start = 1'b1; step_req = 1'b1;
    @(posedge clk); #1 start = 1'b0; step_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic prog_linear();
    for (int i = 0; i < 256; i++) begin
      mem_op[i]   = 4'h0;
      mem_next[i] = 8'(i + 1);
      mem_lo[i]   = 20'($urandom);
    end
  endtask

  task automatic prog_random();
    for (int i = 0; i < 256; i++) begin
      mem_op[i]   = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      mem_next[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'(i + 1);
      mem_lo[i]   = 20'($urandom);
    end
  endtask

  // Monitor: pops one expectation per DUT-presented event.
  ev_t  mon_e;
  logic prev_cpu_rst = 1'b0;
  logic prev_halted = 1'b0;
  int   rst_cnt = 0;
  bit   ok;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_cpu_rst && !cpu_rst && !rst) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rst_release: unexpected release after %0d hold cycles, want none", rst_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          ok = (mon_e.kind == K_RSTREL) && (rst_cnt == mon_e.count) && !cpu_en && !halted
               && (cause == 3'd0) && (cnt == 16'd0);
          if (!ok) begin
            n_err++;
            $display("FAIL rst_release: got hold=%0d en=%0d halted=%0d cause=%0d count=%0d, want kind=%0d hold=%0d en=0 halted=0 cause=0 count=0",
                     rst_cnt, cpu_en, halted, cause, cnt, mon_e.kind, mon_e.count);
          end
        end
      end
      if (rst || !cpu_rst) rst_cnt = 0;
      else                 rst_cnt++;

      if (cpu_en) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL exec: unexpected cpu_en at pc=%0d count=%0d, want none", pc, cnt);
        end else begin
          mon_e = exp_q.pop_front();
          ok = (mon_e.kind == K_EXEC) && (int'(pc) == mon_e.pc) && (int'(cnt) == mon_e.count)
               && (cause == 3'd0) && !halted && !cpu_rst;
          if (!ok) begin
            n_err++;
            $display("FAIL exec: got pc=%0d count=%0d cause=%0d, want kind=%0d pc=%0d count=%0d cause=%0d",
                     pc, cnt, cause, mon_e.kind, mon_e.pc, mon_e.count, mon_e.cause);
          end
        end
      end

      if (halted && !prev_halted) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL halt: unexpected halt pc=%0d cause=%0d count=%0d, want none", pc, cause, cnt);
        end else begin
          mon_e = exp_q.pop_front();
          ok = (mon_e.kind == K_HALT) && (int'(pc) == mon_e.pc) && (int'(cause) == mon_e.cause)
               && (int'(cnt) == mon_e.count) && !cpu_en;
          if (!ok) begin
            n_err++;
            $display("FAIL halt: got pc=%0d cause=%0d count=%0d en=%0d, want kind=%0d pc=%0d cause=%0d count=%0d en=0",
                     pc, cause, cnt, cpu_en, mon_e.kind, mon_e.pc, mon_e.cause, mon_e.count);
          end
        end
      end
      prev_cpu_rst = cpu_rst;
      prev_halted  = halted;
    end
  end

  initial begin
    int r;
    int hq;
    int cut;
    prog_linear();
    m_pc = 0; m_cnt = 0; m_in_halt = 0;
    push(K_RSTREL, 0, 0, RSTC);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (RSTC + 3) @(posedge clk);
    #1;

    // Halt opcode at PC 5.
    mem_op[5] = 4'hF;
    do_run(-1, -1, 1'b0);
    mem_op[5] = 4'h0;
    do_soft();

    // Breakpoint at 3, resume past it until the watchdog fires.
    bp_en = 1'b1; bp_addr = 8'h03;
    do_run(-1, -1, 1'b0);
    do_run(-1, -1, 1'b0);

    // Three steps, then a step onto a halt opcode.
    bp_en = 1'b0;
    do_step();
    do_step();
    do_step();
    mem_op[13] = 4'hF;
    do_step();
    mem_op[13] = 4'h0;
    do_blocked();
    do_soft();
    do_blocked();

    // Infinite loop: watchdog, then immediate re-trigger on resume.
    mem_next[2] = 8'h00;
    do_run(-1, -1, 1'b0);
    do_run(-1, -1, 1'b0);
    do_soft();

    // halt_req and breakpoint in the same cycle.
    bp_en = 1'b1; bp_addr = 8'h02;
    do_run(2, -1, 1'b0);
    do_soft();
    bp_en = 1'b0;

    // Async reset and soft reset mid-run.
    do_run(-1, 3, 1'b1);
    do_run(-1, 4, 1'b0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        if ($urandom_range(0, 2) == 0) prog_random();
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = 8'($urandom_range(0, 15));
        hq      = $urandom_range(0, 14);
        cut     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1;
        do_run(hq, cut, 1'($urandom_range(0, 1)));
      end else if (r <= 7) begin
        do_step();
      end else if (r == 8) begin
        do_soft();
      end else begin
        do_blocked();
      end
    end

    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected events never seen, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run-control sequencer for the 8-bit single-cycle CPU (24-bit instructions, opcode in Instr[23:20], 8-bit PC).
- Holds the CPU in reset after power-up or soft reset, then gates CPU execution with a clock enable.
- Supports start/resume, external halt, single-step, PC breakpoint, halt-opcode detection and a cycle watchdog.
- Sits between the test/debug host and the CPU top. It observes the CPU's PC and current instruction.

Parameters:
- PC_W, 8, PC/breakpoint address width
- CNT_W, 16, executed-cycle counter width
- RST_CYCLES, 4, CPU reset hold length in cycles (>=1)
- HALT_OPCODE, 4'hF, opcode value that stops execution
- WDOG_LIMIT, 1000, executed cycles before forced halt; 0 disables

Ports:
- CLK  in  1  clock
- reset  in  1  asynchronous active-high reset
- soft_rst  in  1  pulse: re-enter reset hold
- start  in  1  pulse: run from IDLE / resume from HALT
- halt_req  in  1  level: stop before next instruction
- step_req  in  1  pulse: execute exactly one instruction
- bp_enable  in  1  breakpoint armed
- bp_addr  in  PC_W  breakpoint PC
- pc  in  PC_W  current CPU PC
- instr  in  24  current CPU instruction
- cpu_rst  out  1  reset to CPU (registered)
- cpu_en  out  1  CPU state-update enable (combinational from state + stop conditions)
- halted  out  1  state==HALT
- halt_cause  out  3  0 none, 1 ext, 2 bp, 3 halt-op, 4 watchdog, 5 step
- cycle_count  out  CNT_W  instructions executed since last start from IDLE

Behaviour:
- reset (async) or soft_rst (sync, highest priority): state=RST_HOLD, hold counter=0, cpu_rst=1, cpu_en=0, halted=0, halt_cause=0, cycle_count=0, skip_bp=0. Applies in any state, including mid-run.
- RST_HOLD: cpu_rst=1 for exactly RST_CYCLES cycles after reset release, then go to IDLE; cpu_rst=0 from the first IDLE cycle.
- IDLE: cpu_en=0.
  - start -> RUN; cycle_count cleared; halt_cause=0.
  - Else step_req -> STEP.
  - Priority: soft_rst > halt_req > start > step_req. halt_req in IDLE keeps IDLE.
- RUN stop conditions, evaluated each cycle on the current pc/instr, in priority order:
  1. halt_req (cause 1).
  2. bp_enable && pc==bp_addr && !skip_bp (cause 2).
  3. instr[23:20]==HALT_OPCODE (cause 3).
  4. WDOG_LIMIT!=0 && cycle_count==WDOG_LIMIT (cause 4).
- RUN, on a stop: cpu_en=0 in that same cycle (the instruction is NOT executed); next state HALT; halt_cause latched.
- RUN, otherwise: cpu_en=1, cycle_count+1 (saturates at all-ones), skip_bp cleared.
- STEP: lasts one cycle.
  - cpu_en=1 unless instr opcode==HALT_OPCODE, which gives cpu_en=0 and cause 3.
  - Breakpoint is ignored in STEP.
  - halt_req during STEP also gives cpu_en=0 and cause 1.
  - Next state HALT, cause 5 if the instruction executed. cycle_count increments if executed.
- HALT: halted=1, cpu_en=0.
  - start -> RUN with skip_bp=1 (first RUN cycle ignores breakpoint so execution proceeds past it); cycle_count retained.
  - step_req -> STEP.
  - halt_req held high keeps HALT (overrides start/step).
  - Resume onto a halt opcode re-halts immediately with cpu_en=0; only soft_rst/reset leaves that condition.
- halt_cause holds its value until the next RUN/STEP entry (cleared to 0 on entry, rewritten on exit).
- Watchdog compares executed cycles, not wall cycles. Resume after watchdog halt re-triggers immediately unless started from IDLE.
- cycle_count saturation takes precedence; no wrap.

Test Plan:
- reset high 3 cycles, release, RST_CYCLES=4 -> cpu_rst=1 for exactly 4 cycles after release, IDLE thereafter, all outputs 0.
- start; program at PC 0..5, instr at PC 5 opcode 4'hF -> cpu_en=1 for 5 cycles, 0 at PC 5; halted=1, halt_cause=3, cycle_count=5.
- bp_enable=1, bp_addr=8'h03, start -> halts with pc=3 unexecuted, cause 2, count=3; start again -> PC 3 executes, runs on, no re-halt at 3.
- From HALT, 3 step_req pulses spaced 4 cycles -> exactly 3 single cpu_en cycles, cause 5, count +3; step onto halt opcode -> cpu_en stays 0, cause 3.
- WDOG_LIMIT=10, infinite loop program -> cpu_en high 10 cycles, then halt cause 4, count=10; halt_req and breakpoint asserted same cycle -> cause 1.
- Async reset and soft_rst mid-RUN -> cpu_en=0 immediately (reset) / next cycle (soft_rst), RST_HOLD entered, count=0.
